// File: rtl/calc_ctrl.sv
// Calculator command sequencer: builds binary operands A/B from keypad commands,
// schedules add/sub (single cycle) and shift-add multiply (WIDTH cycles), and
// reports the display value and status.
// Optional feature macro: CALC_DIV_EN adds command 1101 (divide) backed by a
// WIDTH-cycle restoring divider. Without it, 1101 is ignored and S_DIV is unreachable.
module calc_ctrl #(
  parameter int unsigned WIDTH      = 27,
  parameter int unsigned MAX_DIGITS = 8,
  parameter int unsigned MAX_VAL    = 99999999
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [3:0]       cmd,
  output logic             cmd_ready,
  output logic [WIDTH-1:0] disp_value,
  output logic [1:0]       status,
  output logic             done,
  output logic [2:0]       EA,
  output logic [2:0]       PE
);

  typedef enum logic [2:0] {
    SEnterA = 3'd0,
    SOp     = 3'd1,
    SEnterB = 3'd2,
    SMul    = 3'd3,
    SDiv    = 3'd4,
    SResult = 3'd5,
    SError  = 3'd6
  } state_e;

  typedef enum logic [1:0] {OpAdd, OpSub, OpMul, OpDiv} op_e;

  localparam int unsigned CntW  = $clog2(MAX_DIGITS + 1);
  localparam int unsigned StepW = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0]     MaxValS = (WIDTH + 1)'(MAX_VAL);
  localparam logic [2*WIDTH-1:0] MaxValP = (2 * WIDTH)'(MAX_VAL);
  localparam logic [WIDTH-1:0]   Ten     = WIDTH'(10);
  localparam logic [CntW-1:0]    MaxCnt  = CntW'(MAX_DIGITS);
  localparam logic [StepW-1:0]   LastStep = StepW'(WIDTH);

  // Number of significant decimal digits of v (0 for v == 0)
  function automatic logic [CntW-1:0] digit_count(input logic [WIDTH-1:0] v);
    logic [CntW-1:0]  n;
    longint unsigned  p;
    n = '0;
    p = 1;
    for (int i = 0; i < int'(MAX_DIGITS); i++) begin
      if (64'(v) >= p) n = n + CntW'(1);
      p = p * 10;
    end
    return n;
  endfunction

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CntW-1:0]    cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;
  logic [1:0]         status_q, status_d;
  logic [WIDTH-1:0]   disp_q, disp_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [StepW-1:0]   step_q, step_d;
`ifdef CALC_DIV_EN
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d;
  logic [WIDTH:0]     rem_shift;
`endif

  logic             is_digit, is_op, is_eq, is_bs, accept, eval;
  op_e              cmd_op;
  logic [WIDTH-1:0] digit, b_eval;
  logic [WIDTH:0]   sum;

  assign cmd_ready = (state_q != SMul) && (state_q != SDiv);
  assign accept    = cmd_valid && cmd_ready;

  // Command decode
  always_comb begin
    digit    = WIDTH'(cmd);
    is_digit = (cmd <= 4'd9);
    is_eq    = (cmd == 4'hE);
    is_bs    = (cmd == 4'hF);
    is_op    = 1'b0;
    cmd_op   = OpAdd;
    case (cmd)
      4'hA: begin is_op = 1'b1; cmd_op = OpAdd; end
      4'hB: begin is_op = 1'b1; cmd_op = OpSub; end
      4'hC: begin is_op = 1'b1; cmd_op = OpMul; end
`ifdef CALC_DIV_EN
      4'hD: begin is_op = 1'b1; cmd_op = OpDiv; end
`endif
      default: ;
    endcase
  end

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    step_d   = step_q;
    eval     = 1'b0;
`ifdef CALC_DIV_EN
    rem_d     = rem_q;
    quo_d     = quo_q;
    rem_shift = {rem_q, quo_q[WIDTH-1]};
`endif
    // '=' straight from S_OP evaluates with B = 0
    b_eval = (state_q == SOp) ? '0 : b_q;
    sum    = {1'b0, a_q} + {1'b0, b_eval};

    case (state_q)
      SEnterA: begin
        if (accept) begin
          if (is_digit && cnt_a_q != MaxCnt) begin
            a_d     = a_q * Ten + digit;
            cnt_a_d = cnt_a_q + CntW'(1);
          end else if (is_bs && cnt_a_q != '0) begin
            a_d     = a_q / Ten;
            cnt_a_d = cnt_a_q - CntW'(1);
          end else if (is_op) begin
            op_d    = cmd_op;
            state_d = SOp;
          end
        end
      end
      SOp: begin
        if (accept) begin
          if (is_digit) begin
            b_d     = digit;
            cnt_b_d = CntW'(1);
            state_d = SEnterB;
          end else if (is_op) begin
            op_d = cmd_op;
          end else if (is_eq) begin
            b_d     = '0;
            cnt_b_d = '0;
            eval    = 1'b1;
          end
        end
      end
      SEnterB: begin
        if (accept) begin
          if (is_digit && cnt_b_q != MaxCnt) begin
            b_d     = b_q * Ten + digit;
            cnt_b_d = cnt_b_q + CntW'(1);
          end else if (is_bs && cnt_b_q != '0) begin
            b_d     = b_q / Ten;
            cnt_b_d = cnt_b_q - CntW'(1);
          end else if (is_eq) begin
            eval = 1'b1;
          end
        end
      end
      SMul: begin
        if (step_q == LastStep) begin
          if (acc_q > MaxValP) begin
            state_d = SError;
          end else begin
            res_d   = acc_q[WIDTH-1:0];
            neg_d   = 1'b0;
            state_d = SResult;
          end
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
          step_d   = step_q + StepW'(1);
        end
      end
`ifdef CALC_DIV_EN
      SDiv: begin
        if (step_q == LastStep) begin
          res_d   = quo_q;
          neg_d   = 1'b0;
          state_d = SResult;
        end else begin
          // Restoring step: shift next dividend bit in, subtract when it fits
          if (rem_shift >= {1'b0, b_q}) begin
            rem_d = WIDTH'(rem_shift - {1'b0, b_q});
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          step_d = step_q + StepW'(1);
        end
      end
`endif
      SResult: begin
        if (accept) begin
          if (is_digit) begin
            a_d     = digit;
            cnt_a_d = CntW'(1);
            neg_d   = 1'b0;
            state_d = SEnterA;
          end else if (is_op) begin
            a_d     = res_q;
            cnt_a_d = digit_count(res_q);
            op_d    = cmd_op;
            neg_d   = 1'b0;
            state_d = SOp;
          end
        end
      end
      SError: begin
        if (accept && is_digit) begin
          a_d     = digit;
          cnt_a_d = CntW'(1);
          neg_d   = 1'b0;
          state_d = SEnterA;
        end
      end
      default: state_d = SEnterA;
    endcase

    if (eval) begin
      case (op_q)
        OpAdd: begin
          if (sum > MaxValS) begin
            state_d = SError;
          end else begin
            res_d   = sum[WIDTH-1:0];
            neg_d   = 1'b0;
            state_d = SResult;
          end
        end
        OpSub: begin
          if (a_q >= b_eval) begin
            res_d = a_q - b_eval;
            neg_d = 1'b0;
          end else begin
            res_d = b_eval - a_q;
            neg_d = 1'b1;
          end
          state_d = SResult;
        end
        OpMul: begin
          mcand_d  = {{WIDTH{1'b0}}, a_q};
          mplier_d = b_eval;
          acc_d    = '0;
          step_d   = '0;
          state_d  = SMul;
        end
`ifdef CALC_DIV_EN
        OpDiv: begin
          if (b_eval == '0) begin
            state_d = SError;
          end else begin
            rem_d   = '0;
            quo_d   = a_q;
            step_d  = '0;
            state_d = SDiv;
          end
        end
`endif
        default: ;
      endcase
    end

    case (state_d)
      SEnterA, SOp:        disp_d = a_d;
      SEnterB, SMul, SDiv: disp_d = b_d;
      SResult:             disp_d = res_d;
      default:             disp_d = '0;
    endcase

    case (state_d)
      SMul, SDiv: status_d = 2'b01;
      SError:     status_d = 2'b10;
      SResult:    status_d = neg_d ? 2'b11 : 2'b00;
      default:    status_d = 2'b00;
    endcase

    done_d = (state_d != state_q) && ((state_d == SResult) || (state_d == SError));
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= SEnterA;
      op_q     <= OpAdd;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      status_q <= 2'b00;
      disp_q   <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      step_q   <= '0;
`ifdef CALC_DIV_EN
      rem_q    <= '0;
      quo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      status_q <= status_d;
      disp_q   <= disp_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      step_q   <= step_d;
`ifdef CALC_DIV_EN
      rem_q    <= rem_d;
      quo_q    <= quo_d;
`endif
    end
  end

  assign disp_value = disp_q;
  assign status     = status_q;
  assign done       = done_q;
  assign EA         = state_q;
  assign PE         = state_d;

endmodule
